// File: rtl/rom_arb_pkg.sv
// rom_arb_pkg: shared types and constants for the ROM burst arbiter.
//   state_e    - arbiter FSM states (IDLE, BURST)
//   rsp_tag_t  - tag travelling alongside each ROM read: owner and last-byte flag
//   OWNER_W    - width of a requester index (covers up to 4 requesters)
//   MAX_BURST  - longest burst for the default 4-bit length field
package rom_arb_pkg;

    localparam int OWNER_W   = 2;
    localparam int LEN_W_DEF = 4;
    localparam int MAX_BURST = 2 ** LEN_W_DEF;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_e;

    typedef struct packed {
        logic [OWNER_W-1:0] owner;
        logic               last;
    } rsp_tag_t;

endpackage

// File: rtl/rom_arb_pick.sv
// rom_arb_pick: combinational winner selection.
//   req         - request vector, one bit per requester
//   ptr         - last winner; the search starts just above it (ROM_ARB_RR_EN only)
//   grant       - one-hot winner
//   grant_idx   - binary index of the winner
//   grant_valid - at least one request present
// Build option ROM_ARB_RR_EN: round-robin starting at ptr+1 and wrapping.
// Without it: fixed priority, lowest index wins, and there is no ptr port.
module rom_arb_pick
    import rom_arb_pkg::*;
#(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0] req,
`ifdef ROM_ARB_RR_EN
    input  logic [OWNER_W-1:0] ptr,
`endif
    output logic [NUM_REQ-1:0] grant,
    output logic [OWNER_W-1:0] grant_idx,
    output logic               grant_valid
);

    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
`ifdef ROM_ARB_RR_EN
        // Loops run downward so the last hit is the lowest index. The second
        // loop (indices above ptr) overrides the wrapped-around first loop.
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[i] && (i <= int'(ptr))) begin
                grant_idx   = OWNER_W'(i);
                grant_valid = 1'b1;
            end
        end
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[i] && (i > int'(ptr))) begin
                grant_idx   = OWNER_W'(i);
                grant_valid = 1'b1;
            end
        end
`else
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                grant_idx   = OWNER_W'(i);
                grant_valid = 1'b1;
            end
        end
`endif
        for (int i = 0; i < NUM_REQ; i++) begin
            grant[i] = grant_valid && (grant_idx == OWNER_W'(i));
        end
    end

endmodule

// File: rtl/rom_burst_arbiter.sv
// rom_burst_arbiter: shares a single-port registered-address ROM between
// NUM_REQ requesters, each reading bursts of 1..2^LEN_W consecutive bytes.
//   req_valid/req_addr/req_len/req_ready - per-requester request channel
//   rsp_valid/rsp_data/rsp_last          - shared response bus, one-hot owner
//   rom_addr/rom_q                       - ROM port; rom_q is valid one cycle
//                                          after rom_addr
//   busy                                 - FSM is in BURST
//   dbg_state                            - current FSM state
// Build option ROM_ARB_RR_EN selects round-robin arbitration (see rom_arb_pick).
//
// Handshake: a request transfers in a cycle where req_valid[i] & req_ready[i].
// Once req_valid[i] rises, req_valid/req_addr/req_len of requester i stay
// stable until that transfer; req_ready never waits on anything but state and
// req_valid. The response bus has no back-pressure.
module rom_burst_arbiter
    import rom_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int LEN_W   = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*LEN_W-1:0]  req_len,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_data,
    output logic                      rsp_last,
    output logic                      busy,
    output logic [ADDR_W-1:0]         rom_addr,
    input  logic [DATA_W-1:0]         rom_q,
    output state_e                    dbg_state
);

    state_e             state;
    logic [LEN_W-1:0]   count;
    logic [OWNER_W-1:0] owner;
    logic               resp_v_q;
    rsp_tag_t           tag_q;

    logic [NUM_REQ-1:0] grant;
    logic [OWNER_W-1:0] grant_idx;
    logic               grant_valid;
    logic               arb_en;
    logic               accept;
    logic [ADDR_W-1:0]  sel_addr;
    logic [LEN_W-1:0]   sel_len;

`ifdef ROM_ARB_RR_EN
    logic [OWNER_W-1:0] rr_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= OWNER_W'(NUM_REQ - 1);
        end else if (accept) begin
            rr_ptr <= grant_idx;
        end
    end
`endif

    rom_arb_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .req         (req_valid),
`ifdef ROM_ARB_RR_EN
        .ptr         (rr_ptr),
`endif
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    // Arbitrate when idle, or on the last issue cycle so the next burst
    // follows without a bubble.
    assign arb_en    = (state == IDLE) || (count == '0);
    assign accept    = rst_n && arb_en && grant_valid;
    assign req_ready = accept ? grant : '0;

    always_comb begin
        sel_addr = '0;
        sel_len  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_addr = req_addr[i*ADDR_W +: ADDR_W];
                sel_len  = req_len[i*LEN_W +: LEN_W];
            end
        end
    end

    // rom_addr doubles as the burst address counter: it is loaded with the
    // start address on accept so the first address is on the ROM port in the
    // first BURST cycle, then steps (wrapping) each issue cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            rom_addr <= '0;
            count    <= '0;
            owner    <= '0;
            resp_v_q <= 1'b0;
            tag_q    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    resp_v_q <= 1'b0;
                    if (accept) begin
                        rom_addr <= sel_addr;
                        count    <= sel_len;
                        owner    <= grant_idx;
                        state    <= BURST;
                    end
                end
                BURST: begin
                    resp_v_q    <= 1'b1;
                    tag_q.owner <= owner;
                    tag_q.last  <= (count == '0);
                    if (count != '0) begin
                        rom_addr <= rom_addr + 1'b1;
                        count    <= count - 1'b1;
                    end else if (accept) begin
                        rom_addr <= sel_addr;
                        count    <= sel_len;
                        owner    <= grant_idx;
                    end else begin
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        rsp_valid = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            rsp_valid[i] = resp_v_q && (tag_q.owner == OWNER_W'(i));
        end
    end

    assign rsp_data  = rom_q;
    assign rsp_last  = resp_v_q && tag_q.last;
    assign busy      = (state == BURST);
    assign dbg_state = state;

endmodule

// File: tb/tb_rom_burst_arbiter.sv
// tb_rom_burst_arbiter: directed bench for rom_burst_arbiter with a
// registered-address ROM model holding byte[a] = a ^ 8'h5A. Inputs are
// driven on the falling edge; outputs are sampled on the falling edge.
module tb_rom_burst_arbiter;
    import rom_arb_pkg::*;

    localparam int NUM_REQ = 2;
    localparam int ADDR_W  = 8;
    localparam int DATA_W  = 8;
    localparam int LEN_W   = 4;
    localparam int W       = NUM_REQ + DATA_W + 1;

    logic                      clk;
    logic                      rst_n;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*LEN_W-1:0]  req_len;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]         rsp_data;
    logic                      rsp_last;
    logic                      busy;
    logic [ADDR_W-1:0]         rom_addr;
    logic [DATA_W-1:0]         rom_q;
    state_e                    dbg_state;

    int n_chk = 0;
    int n_err = 0;
    logic [W-1:0] exp_q[$];

    rom_burst_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .LEN_W   (LEN_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_len   (req_len),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_last  (rsp_last),
        .busy      (busy),
        .rom_addr  (rom_addr),
        .rom_q     (rom_q),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset / ROM model ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [ADDR_W-1:0] rom_a_q;
    always @(posedge clk) rom_a_q <= rom_addr;
    assign rom_q = rom_a_q ^ 8'h5A;

    // ---------------- driver tasks ----------------
    task automatic step();
        @(negedge clk);
    endtask

    task automatic set_req(input int i, input logic v, input logic [7:0] a, input logic [3:0] l);
        req_valid[i]             = v;
        req_addr[i*ADDR_W +: 8]  = a;
        req_len[i*LEN_W +: 4]    = l;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_beat(input logic [1:0] own, input logic [7:0] addr, input logic last);
        exp_q.push_back({own, addr ^ 8'h5A, last});
    endtask

    // ---------------- scoreboard ----------------
    always @(negedge clk) begin
        logic [W-1:0] e;
        if (rst_n && rsp_valid != '0) begin
            n_chk++;
            if (exp_q.size() == 0) begin
                n_err++;
                $error("FAIL rsp_unexpected: observed=%0h expected=none", {rsp_valid, rsp_data, rsp_last});
            end else begin
                e = exp_q.pop_front();
                assert ({rsp_valid, rsp_data, rsp_last} === e) else begin
                    n_err++;
                    $error("FAIL rsp_beat: observed=%0h expected=%0h", {rsp_valid, rsp_data, rsp_last}, e);
                end
            end
        end
    end

    // Requester rule: once raised, req_valid stays up until accepted.
    logic [NUM_REQ-1:0] pend;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (pend[i] && !req_valid[i]) begin
                    n_err++;
                    $error("FAIL req_drop: requester %0d dropped req_valid before ready", i);
                end
            end
            pend <= req_valid & ~req_ready;
        end
    end

    // ---------------- directed sequence ----------------
    initial begin
        logic [1:0] rdy_e[6];
        logic [7:0] addr_of[2];

        rst_n     = 1'b0;
        req_valid = '0;
        req_addr  = '0;
        req_len   = '0;

        // Reset state, with a request present to show req_ready is held low.
        step();
        set_req(0, 1'b1, 8'h10, 4'd3);
        #1;
        chk("ready_in_reset", 32'(req_ready), 32'h0);
        chk("rst_busy",       32'(busy),      32'h0);
        chk("rst_rsp_valid",  32'(rsp_valid), 32'h0);
        chk("rst_rsp_last",   32'(rsp_last),  32'h0);
        chk("rst_rom_addr",   32'(rom_addr),  32'h0);
        set_req(0, 1'b0, 8'h00, 4'd0);
        step();
        rst_n = 1'b1;
        step();

        // 1) Single burst: req0 @0x10, 4 bytes.
        set_req(0, 1'b1, 8'h10, 4'd3);
        #1 chk("t1_ready", 32'(req_ready), 32'h1);
        push_beat(2'b01, 8'h10, 1'b0);
        push_beat(2'b01, 8'h11, 1'b0);
        push_beat(2'b01, 8'h12, 1'b0);
        push_beat(2'b01, 8'h13, 1'b1);
        step();  // T+1
        set_req(0, 1'b0, 8'h00, 4'd0);
        chk("t1_busy_t1",  32'(busy),      32'h1);
        chk("t1_addr_t1",  32'(rom_addr),  32'h10);
        chk("t1_rsp_t1",   32'(rsp_valid), 32'h0);
        step();  // T+2
        chk("t1_rsp_t2",   32'(rsp_valid), 32'h1);
        chk("t1_data_t2",  32'(rsp_data),  32'h4A);
        step();  // T+3
        chk("t1_data_t3",  32'(rsp_data),  32'h4B);
        step();  // T+4
        chk("t1_data_t4",  32'(rsp_data),  32'h48);
        chk("t1_busy_t4",  32'(busy),      32'h1);
        step();  // T+5
        chk("t1_data_t5",  32'(rsp_data),  32'h49);
        chk("t1_last_t5",  32'(rsp_last),  32'h1);
        chk("t1_busy_t5",  32'(busy),      32'h0);
        step();  // T+6
        chk("t1_rsp_t6",   32'(rsp_valid), 32'h0);
        step();

        // 2) Address wrap: req1 @0xFE, 3 bytes.
        set_req(1, 1'b1, 8'hFE, 4'd2);
        #1 chk("t2_ready", 32'(req_ready), 32'h2);
        push_beat(2'b10, 8'hFE, 1'b0);
        push_beat(2'b10, 8'hFF, 1'b0);
        push_beat(2'b10, 8'h00, 1'b1);
        step();
        set_req(1, 1'b0, 8'h00, 4'd0);
        chk("t2_addr_fe", 32'(rom_addr), 32'hFE);
        step();
        chk("t2_addr_ff", 32'(rom_addr), 32'hFF);
        chk("t2_data_a4", 32'(rsp_data), 32'hA4);
        step();
        chk("t2_addr_00", 32'(rom_addr), 32'h00);
        chk("t2_busy_3rd", 32'(busy),    32'h1);
        chk("t2_data_a5", 32'(rsp_data), 32'hA5);
        step();
        chk("t2_busy_drop", 32'(busy),     32'h0);
        chk("t2_addr_hold", 32'(rom_addr), 32'h00);
        chk("t2_data_5a",   32'(rsp_data), 32'h5A);
        chk("t2_last",      32'(rsp_last), 32'h1);
        step();
        step();

        // 3) Contention, single-byte bursts, both requesters held.
`ifdef ROM_ARB_RR_EN
        rdy_e = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b00};
`else
        rdy_e = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b00};
`endif
        addr_of[0] = 8'h20;
        addr_of[1] = 8'h30;
        for (int c = 0; c < 6; c++) begin
            set_req(0, (c < 4), addr_of[0], 4'd0);
            set_req(1, (c < 5), addr_of[1], 4'd0);
            #1 chk($sformatf("t3_ready_c%0d", c), 32'(req_ready), 32'(rdy_e[c]));
            if (rdy_e[c] == 2'b01) push_beat(2'b01, addr_of[0], 1'b1);
            if (rdy_e[c] == 2'b10) push_beat(2'b10, addr_of[1], 1'b1);
            if (c >= 2) chk($sformatf("t3_nobubble_c%0d", c), 32'(rsp_valid), 32'(rdy_e[c-2]));
            step();
        end
        chk("t3_rsp_c6", 32'(rsp_valid), 32'(rdy_e[4]));
        step();
        chk("t3_rsp_c7", 32'(rsp_valid), 32'h0);
        step();

        // 4) Back-to-back: req0 16 bytes, req1 raised mid-burst.
        set_req(0, 1'b1, 8'h40, 4'd15);
        #1 chk("t4_ready0", 32'(req_ready), 32'h1);
        for (int k = 0; k < 16; k++) push_beat(2'b01, 8'(8'h40 + k), (k == 15));
        push_beat(2'b10, 8'h80, 1'b0);
        push_beat(2'b10, 8'h81, 1'b1);
        step();  // T+1
        set_req(0, 1'b0, 8'h00, 4'd0);
        for (int c = 2; c <= 16; c++) begin
            step();  // T+c
            if (c == 5) set_req(1, 1'b1, 8'h80, 4'd1);
            if (c >= 5) begin
                #1 chk($sformatf("t4_ready1_c%0d", c), 32'(req_ready), (c == 16) ? 32'h2 : 32'h0);
            end
        end
        step();  // T+17
        set_req(1, 1'b0, 8'h00, 4'd0);
        chk("t4_last0", 32'(rsp_last),  32'h1);
        chk("t4_own0",  32'(rsp_valid), 32'h1);
        step();  // T+18
        chk("t4_own1",  32'(rsp_valid), 32'h2);
        step();
        step();
        chk("t4_idle", 32'(busy), 32'h0);

        // 5) Reset mid-burst: 8-byte burst, reset after 3 bytes returned.
        set_req(0, 1'b1, 8'h60, 4'd7);
        #1 chk("t5_ready", 32'(req_ready), 32'h1);
        push_beat(2'b01, 8'h60, 1'b0);
        push_beat(2'b01, 8'h61, 1'b0);
        push_beat(2'b01, 8'h62, 1'b0);
        step();  // T+1
        set_req(0, 1'b0, 8'h00, 4'd0);
        step();
        step();
        step();  // T+4: third byte on the bus
        #2 rst_n = 1'b0;
        #1;
        chk("t5_rst_rsp",  32'(rsp_valid), 32'h0);
        chk("t5_rst_busy", 32'(busy),      32'h0);
        chk("t5_rst_addr", 32'(rom_addr),  32'h0);
        step();
        step();
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step();
            chk($sformatf("t5_quiet_c%0d", c), 32'({rsp_valid, busy}), 32'h0);
        end
        set_req(1, 1'b1, 8'h05, 4'd0);
        #1 chk("t5_new_ready", 32'(req_ready), 32'h2);
        push_beat(2'b10, 8'h05, 1'b1);
        step();
        set_req(1, 1'b0, 8'h00, 4'd0);
        step();
        chk("t5_new_data", 32'(rsp_data), 32'h5F);
        step();
        step();

        chk("exp_q_empty", 32'(exp_q.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/rom_burst_arbiter.md
# rom_burst_arbiter

Shares the single-read-port 256x8 boot/asset ROM between NUM_REQ requesters (e.g. processor fetch unit and display/sprite engine). Each requester asks for a burst of 1..2^LEN_W consecutive bytes. The arbiter grants one requester at a time and streams incrementing addresses into the ROM. It returns each byte, tagged to its owner, on a shared data bus. The ROM registers its address on clk, so data arrives one cycle after the address is issued.

## Interface
- NUM_REQ, 2, number of requesters (2..4)
- ADDR_W, 8, ROM address width
- DATA_W, 8, ROM data width
- LEN_W, 4, burst length field width; field encodes length-1
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NUM_REQ  per-requester request pending
- req_addr  in  NUM_REQ*ADDR_W  start address, slice i for requester i
- req_len  in  NUM_REQ*LEN_W  burst length minus 1, slice i
- req_ready  out  NUM_REQ  one-hot accept; transfer when req_valid[i] & req_ready[i]
- rsp_valid  out  NUM_REQ  one-hot, byte on rsp_data belongs to requester i
- rsp_data  out  DATA_W  returned byte (pass-through of rom_q)
- rsp_last  out  1  final byte of the burst
- busy  out  1  FSM in BURST
- rom_addr  out  ADDR_W  registered address to ROM
- rom_q  in  DATA_W  ROM data, valid the cycle after rom_addr

## Operation
- Clock is clk. Reset is rst_n, asynchronous, active-low.
- Reset values: state IDLE, rom_addr 0, count 0, rsp pipeline valid 0, rr pointer NUM_REQ-1.
  - Consequence: req_ready, rsp_valid, rsp_last and busy are all 0.
- req_ready is combinational from state and req_valid. It is forced 0 while rst_n is low.
- FSM states: IDLE, BURST.
  - IDLE: if any req_valid, arbitrate, assert req_ready[winner] that cycle and load the burst registers. Next state is BURST.
    - Burst registers: cur_addr=req_addr, count=req_len, owner=winner.
  - BURST, each cycle:
    - rom_addr<=cur_addr.
    - cur_addr<=cur_addr+1, modulo 2^ADDR_W, so 0xFF wraps to 0x00.
    - count<=count-1.
    - Push {owner, last=(count==0)} into a 1-deep response register.
  - Last issue cycle (count==0): arbitrate again.
    - If a winner exists, accept it and stay in BURST. Back-to-back bursts have no bubble.
    - Otherwise go to IDLE.
- Response: rsp_valid = onehot(owner_q) when resp_v_q, rsp_data = rom_q, rsp_last = last_q.
- Requesters hold req_valid, req_addr and req_len stable until accepted. Dropping req_valid before ready is illegal. The bench asserts on it.
- Non-owners' req_valid has no effect mid-burst.
- rom_addr holds its last value in IDLE.
- Reset mid-burst aborts immediately.
  - No further rsp_valid is produced.
  - Partially returned data is not replayed; the requester re-requests.

## Timing
- Accept cycle T (req_ready high).
- First address on rom_addr at T+1. First rsp_valid at T+2.
- Burst of L bytes: rsp_valid high for cycles T+2..T+L+1, with rsp_last at T+L+1.
- Back-to-back: the next burst's first rsp_valid immediately follows the previous rsp_last.
- busy high from T+1 through the last issue cycle.
- Throughput: 1 byte/cycle sustained. Worst-case wait for a requester is (NUM_REQ-1)*2^LEN_W cycles plus 1.

## Configuration
- ROM_ARB_RR_EN defined: round-robin.
  - Search starts at rr_ptr+1 and wraps.
  - rr_ptr<=winner on each accept.
  - After reset, requester 0 has top priority.
- Undefined: fixed priority, lowest index wins. rr_ptr is not instantiated.

## Structure
- Package rom_arb_pkg holds:
  - typedef state_e {IDLE, BURST}
  - typedef rsp_tag_t {owner, last}
  - constant MAX_BURST = 2^LEN_W
- Sub-module rom_arb_pick: combinational req-vector -> one-hot winner plus a valid flag, given the priority pointer. Holds the ROM_ARB_RR_EN choice.
- Bench ROM model: registered-address 256x8 with contents byte[a]=a^8'h5A.

## Test plan
- Single burst: req0 addr 0x10 len 3, no contention.
  - Expect rsp_valid=01 for 4 cycles with data 0x4A,0x4B,0x48,0x49.
  - rsp_last on the 4th; first data 2 cycles after accept.
- Wrap: req1 addr 0xFE len 2.
  - Expect rom_addr FE,FF,00 and data 0xA4,0xA5,0x5A. busy drops after the 3rd address.
- Contention (RR_EN): req0 and req1 held continuously, len 0.
  - Expect grants 0,1,0,1, back-to-back with no bubble cycles.
- Fixed priority (no macro): same stimulus.
  - Expect only requester 0 granted while req_valid[0] high. Requester 1 granted the cycle req0 drops.
- Back-to-back: req0 len 15, then req1 asserted mid-burst.
  - Expect req_ready[1] exactly on req0's last issue cycle.
  - Expect 16 rsp_valid=01 then rsp_valid=10 the next cycle.
- Reset mid-burst: rst_n low 2 cycles during 8-byte burst after 3 bytes.
  - Expect rsp_valid, busy and rom_addr 0 asynchronously.
  - Expect no response after release until a new accept.
